// File: rtl/seq_call_pkg.sv
// Shared opcodes, state encoding, error causes and instruction field extraction for seq_call.
package seq_call_pkg;

    localparam int unsigned OP_W        = 4;
    localparam int unsigned FIELD_MAX_W = 64;

    localparam logic [OP_W-1:0] OP_NO   = 4'h0;
    localparam logic [OP_W-1:0] OP_CI   = 4'h1;
    localparam logic [OP_W-1:0] OP_CR   = 4'h2;
    localparam logic [OP_W-1:0] OP_JI   = 4'h3;
    localparam logic [OP_W-1:0] OP_JR   = 4'h4;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h5;
    localparam logic [OP_W-1:0] OP_JN   = 4'h6;
    localparam logic [OP_W-1:0] OP_WZ   = 4'h7;
    localparam logic [OP_W-1:0] OP_WN   = 4'h8;
    localparam logic [OP_W-1:0] OP_CALL = 4'h9;
    localparam logic [OP_W-1:0] OP_RET  = 4'hA;
    localparam logic [OP_W-1:0] OP_LDC  = 4'hB;
    localparam logic [OP_W-1:0] OP_DJNZ = 4'hC;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_READY = 3'd1,
        ST_WAITZ = 3'd2,
        ST_WAITN = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    function automatic logic [FIELD_MAX_W-1:0] low_mask(input int unsigned w);
        return (FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1);
    endfunction

    // Instruction layout is {op[3:0], A[addr_w-1:0], B[data_w-1:0]}
    function automatic logic [OP_W-1:0] field_op(input logic [FIELD_MAX_W-1:0] inst,
                                                 input int unsigned addr_w,
                                                 input int unsigned data_w);
        logic [FIELD_MAX_W-1:0] sh;
        sh = inst >> (addr_w + data_w);
        return sh[OP_W-1:0];
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] field_a(input logic [FIELD_MAX_W-1:0] inst,
                                                      input int unsigned addr_w,
                                                      input int unsigned data_w);
        return (inst >> data_w) & low_mask(addr_w);
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] field_b(input logic [FIELD_MAX_W-1:0] inst,
                                                      input int unsigned data_w);
        return inst & low_mask(data_w);
    endfunction

endpackage

// File: rtl/seq_call_lifo.sv
// Return-address LIFO; top/full/empty are registered so they are valid the cycle after a push/pop.
module seq_call_lifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            top   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[IDX_W'(cnt)] <= data;
            top              <= data;
            cnt              <= cnt + CNT_W'(1);
            full             <= (cnt + CNT_W'(1)) == CNT_W'(DEPTH);
            empty            <= 1'b0;
        end else if (pop) begin
            // New top is the entry beneath the one being removed
            top   <= mem[IDX_W'(cnt - CNT_W'(2))];
            cnt   <= cnt - CNT_W'(1);
            full  <= 1'b0;
            empty <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/seq_call.sv
// Instruction sequencer: command issue, branches, waits, call/return and a loop counter.
module seq_call
    import seq_call_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CMD_W       = 4,
    parameter int unsigned NUM_DEV     = 8,
    parameter int unsigned NUM_IREG    = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [4+ADDR_W+DATA_W-1:0]   inst,
    input  logic                         inst_en,
    input  logic [NUM_IREG*DATA_W-1:0]   ireg,
    output logic [ADDR_W-1:0]            next,
    output logic [CMD_W+DATA_W-1:0]      oreg,
    output logic [NUM_DEV-1:0]           oreg_wen,
    output logic                         waiting,
    output logic                         error,
    output logic [1:0]                   err_code
);

    localparam int unsigned DEV_W = $clog2(NUM_DEV);
    localparam int unsigned SRC_W = $clog2(NUM_IREG);

    state_t                    state, state_d;
    logic [ADDR_W-1:0]         next_d, pc_inc, fa, stack_top;
    logic [DATA_W-1:0]         fb, sel, wsel, lcnt, lcnt_d, lcnt_dec;
    logic [OP_W-1:0]           op;
    logic [CMD_W-1:0]          cmd;
    logic [DEV_W-1:0]          dev;
    logic [SRC_W-1:0]          src, wsrc, wsrc_d;
    logic [CMD_W+DATA_W-1:0]   oreg_d;
    logic [NUM_DEV-1:0]        wen_d;
    logic [1:0]                err_code_d;
    logic                      push, pop, stack_full, stack_empty;
    logic [DATA_W-1:0]         ireg_a [NUM_IREG];

    assign op  = field_op(FIELD_MAX_W'(inst), ADDR_W, DATA_W);
    assign fa  = ADDR_W'(field_a(FIELD_MAX_W'(inst), ADDR_W, DATA_W));
    assign fb  = DATA_W'(field_b(FIELD_MAX_W'(inst), DATA_W));
    assign cmd = fa[CMD_W-1:0];
    assign dev = fa[DEV_W+CMD_W-1:CMD_W];
    assign src = fb[SRC_W-1:0];

    always_comb begin
        for (int k = 0; k < int'(NUM_IREG); k++) begin
            ireg_a[k] = ireg[k*DATA_W +: DATA_W];
        end
    end

    assign sel      = ireg_a[src];
    assign wsel     = ireg_a[wsrc];
    assign pc_inc   = next + ADDR_W'(1);
    assign lcnt_dec = lcnt - DATA_W'(1);

    seq_call_lifo #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_lifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .data  (pc_inc),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Next-state, stack control and registered-output values
    always_comb begin
        state_d    = state;
        next_d     = next;
        oreg_d     = '0;
        wen_d      = '0;
        err_code_d = err_code;
        lcnt_d     = lcnt;
        wsrc_d     = wsrc;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_RESET: state_d = ST_READY;
            ST_READY: begin
                if (inst_en) begin
                    case (op)
                        OP_NO: next_d = pc_inc;
                        OP_CI: begin
                            oreg_d = {cmd, fb};
                            wen_d  = NUM_DEV'(1) << dev;
                            next_d = pc_inc;
                        end
                        OP_CR: begin
                            oreg_d = {cmd, sel};
                            wen_d  = NUM_DEV'(1) << dev;
                            next_d = pc_inc;
                        end
                        OP_JI: next_d = fa;
                        OP_JR: next_d = ADDR_W'(sel);
                        OP_JZ: next_d = (sel == '0) ? fa : pc_inc;
                        OP_JN: next_d = (sel != '0) ? fa : pc_inc;
                        OP_WZ: begin
                            if (sel == '0) begin
                                next_d = pc_inc;
                            end else begin
                                wsrc_d  = src;
                                state_d = ST_WAITZ;
                            end
                        end
                        OP_WN: begin
                            if (sel != '0) begin
                                next_d = pc_inc;
                            end else begin
                                wsrc_d  = src;
                                state_d = ST_WAITN;
                            end
                        end
                        OP_CALL: begin
                            if (stack_full) begin
                                state_d    = ST_ERROR;
                                next_d     = '0;
                                err_code_d = ERR_OVERFLOW;
                            end else begin
                                push   = 1'b1;
                                next_d = fa;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                state_d    = ST_ERROR;
                                next_d     = '0;
                                err_code_d = ERR_UNDERFLOW;
                            end else begin
                                pop    = 1'b1;
                                next_d = stack_top;
                            end
                        end
                        OP_LDC: begin
                            lcnt_d = fb;
                            next_d = pc_inc;
                        end
                        OP_DJNZ: begin
                            lcnt_d = lcnt_dec;
                            next_d = (lcnt_dec != '0) ? fa : pc_inc;
                        end
                        default: begin
                            state_d    = ST_ERROR;
                            next_d     = '0;
                            err_code_d = ERR_ILLEGAL;
                        end
                    endcase
                end
            end
            ST_WAITZ: begin
                if (wsel == '0) begin
                    next_d  = pc_inc;
                    state_d = ST_READY;
                end
            end
            ST_WAITN: begin
                if (wsel != '0) begin
                    next_d  = pc_inc;
                    state_d = ST_READY;
                end
            end
            ST_ERROR: next_d = '0;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_RESET;
            next     <= '0;
            oreg     <= '0;
            oreg_wen <= '0;
            waiting  <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            lcnt     <= '0;
            wsrc     <= '0;
        end else begin
            state    <= state_d;
            next     <= next_d;
            oreg     <= oreg_d;
            oreg_wen <= wen_d;
            waiting  <= (state_d == ST_WAITZ) || (state_d == ST_WAITN);
            error    <= (state_d == ST_ERROR);
            err_code <= err_code_d;
            lcnt     <= lcnt_d;
            wsrc     <= wsrc_d;
        end
    end

endmodule

// File: tb/tb_seq_call.sv
// Scoreboard bench for seq_call: directed program fragments plus randomized streams against a reference model.
module tb_seq_call;

    localparam int M_RESET = 0;
    localparam int M_READY = 1;
    localparam int M_WZ    = 2;
    localparam int M_WN    = 3;
    localparam int M_ERR   = 4;
    localparam int DEPTH   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] inst;
    logic        inst_en;
    logic [31:0] ireg;
    logic [7:0]  nxt;
    logic [11:0] oreg;
    logic [7:0]  oreg_wen;
    logic        waiting;
    logic        error;
    logic [1:0]  err_code;

    seq_call dut (
        .clock    (clock),
        .reset    (reset),
        .inst     (inst),
        .inst_en  (inst_en),
        .ireg     (ireg),
        .next     (nxt),
        .oreg     (oreg),
        .oreg_wen (oreg_wen),
        .waiting  (waiting),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  next;
        logic [11:0] oreg;
        logic [7:0]  wen;
        logic        waiting;
        logic        error;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int         m_mode, m_pc, m_lcnt, m_wsrc, m_code;
    int         m_stack[$];
    logic [7:0] ir [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_RESET;
        m_pc   = 0;
        m_lcnt = 0;
        m_wsrc = 0;
        m_code = 0;
        m_stack.delete();
    endtask

    // Drive one instruction slot and record what the sequencer must show after the next edge
    task automatic cyc(input logic [3:0] op, input int a, input int b, input logic en);
        exp_t e;
        int   src, sel, pc1;
        @(negedge clock);
        inst    = {op, 8'(a), 8'(b)};
        inst_en = en;
        ireg    = {ir[3], ir[2], ir[1], ir[0]};
        e.oreg  = '0;
        e.wen   = '0;
        pc1     = (m_pc + 1) % 256;
        src     = b % 4;
        sel     = int'(ir[src]);
        case (m_mode)
            M_RESET: m_mode = M_READY;
            M_READY: if (en) begin
                case (op)
                    4'h0: m_pc = pc1;
                    4'h1, 4'h2: begin
                        e.oreg = 12'((a % 16) * 256 + ((op == 4'h1) ? b : sel));
                        e.wen  = 8'(1 << ((a / 16) % 8));
                        m_pc   = pc1;
                    end
                    4'h3: m_pc = a;
                    4'h4: m_pc = sel;
                    4'h5: m_pc = (sel == 0) ? a : pc1;
                    4'h6: m_pc = (sel != 0) ? a : pc1;
                    4'h7, 4'h8: begin
                        if ((sel == 0) == (op == 4'h7)) m_pc = pc1;
                        else begin
                            m_wsrc = src;
                            m_mode = (op == 4'h7) ? M_WZ : M_WN;
                        end
                    end
                    4'h9: begin
                        if (m_stack.size() == DEPTH) begin
                            m_mode = M_ERR;
                            m_code = 2;
                        end else begin
                            m_stack.push_back(pc1);
                            m_pc = a;
                        end
                    end
                    4'hA: begin
                        if (m_stack.size() == 0) begin
                            m_mode = M_ERR;
                            m_code = 3;
                        end else begin
                            m_pc = m_stack.pop_back();
                        end
                    end
                    4'hB: begin
                        m_lcnt = b;
                        m_pc   = pc1;
                    end
                    4'hC: begin
                        m_lcnt = (m_lcnt + 255) % 256;
                        m_pc   = (m_lcnt != 0) ? a : pc1;
                    end
                    default: begin
                        m_mode = M_ERR;
                        m_code = 1;
                    end
                endcase
            end
            M_WZ: if (ir[m_wsrc] == 8'd0) begin
                m_pc   = pc1;
                m_mode = M_READY;
            end
            M_WN: if (ir[m_wsrc] != 8'd0) begin
                m_pc   = pc1;
                m_mode = M_READY;
            end
            default: ;
        endcase
        if (m_mode == M_ERR) m_pc = 0;
        e.next    = 8'(m_pc);
        e.waiting = (m_mode == M_WZ) || (m_mode == M_WN);
        e.error   = (m_mode == M_ERR);
        e.code    = 2'(m_code);
        sb.push_back(e);
    endtask

    task automatic rand_cyc(input logic en);
        cyc(4'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), en);
    endtask

    // Reset asserted mid-cycle (clock high); outputs must clear without waiting for an edge
    task automatic do_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_next", 32'(nxt), 32'd0);
        chk("rst_oreg", 32'(oreg), 32'd0);
        chk("rst_wen", 32'(oreg_wen), 32'd0);
        chk("rst_waiting", 32'(waiting), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        model_reset();
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("next", 32'(nxt), 32'(e.next));
            chk("oreg_wen", 32'(oreg_wen), 32'(e.wen));
            if (e.wen != 8'd0) chk("oreg", 32'(oreg), 32'(e.oreg));
            chk("waiting", 32'(waiting), 32'(e.waiting));
            chk("error", 32'(error), 32'(e.error));
            chk("err_code", 32'(err_code), 32'(e.code));
        end
    end

    initial begin
        int r;
        reset   = 1'b0;
        inst    = '0;
        inst_en = 1'b0;
        ireg    = '0;
        for (int k = 0; k < 4; k++) ir[k] = 8'd0;
        model_reset();
        do_reset();

        // Reset/basic: RESET cycle, NO, CI dev=5 cmd=3 B=0xA7, then idle
        cyc(4'h0, 0, 0, 1'b1);
        cyc(4'h0, 0, 0, 1'b1);
        cyc(4'h1, 8'h53, 8'hA7, 1'b1);
        cyc(4'h0, 0, 0, 1'b0);
        cyc(4'h0, 0, 0, 1'b1);

        // Branches, JR, wrap at 0xFF
        ir[1] = 8'd0;
        ir[2] = 8'h9C;
        cyc(4'h5, 8'h40, 1, 1'b1);
        cyc(4'h6, 8'h40, 1, 1'b1);
        cyc(4'h4, 0, 2, 1'b1);
        cyc(4'h3, 8'hFF, 0, 1'b1);
        cyc(4'h3, 8'h77, 0, 1'b1);
        cyc(4'h3, 8'hFF, 0, 1'b1);
        cyc(4'h0, 0, 0, 1'b1);

        // Wait on ireg3 with garbage instructions meanwhile
        ir[3] = 8'd5;
        cyc(4'h7, 0, 3, 1'b1);
        repeat (4) rand_cyc(1'($urandom_range(0, 1)));
        ir[3] = 8'd0;
        rand_cyc(1'b0);
        cyc(4'h0, 0, 0, 1'b1);

        // Nested call/return, including RET right after CALL
        cyc(4'h3, 8'h05, 0, 1'b1);
        cyc(4'h9, 8'h20, 0, 1'b1);
        cyc(4'h9, 8'h30, 0, 1'b1);
        cyc(4'hA, 0, 0, 1'b1);
        cyc(4'hA, 0, 0, 1'b1);
        cyc(4'h9, 8'h50, 0, 1'b1);
        cyc(4'hA, 0, 0, 1'b1);

        // Loop counter, then DJNZ from zero wraps and jumps
        cyc(4'h3, 8'h10, 0, 1'b1);
        cyc(4'hB, 0, 3, 1'b1);
        repeat (3) cyc(4'hC, 8'h10, 0, 1'b1);
        cyc(4'hB, 0, 0, 1'b1);
        cyc(4'hC, 8'h10, 0, 1'b1);
        cyc(4'hC, 8'h33, 0, 1'b1);

        // Stack overflow
        do_reset();
        repeat (DEPTH + 2) cyc(4'h9, int'($urandom_range(0, 255)), 0, 1'b1);
        repeat (3) rand_cyc(1'b1);

        // Stack underflow
        do_reset();
        cyc(4'h0, 0, 0, 1'b1);
        cyc(4'hA, 0, 0, 1'b1);
        repeat (3) rand_cyc(1'b1);

        // Illegal opcode, terminal until reset
        do_reset();
        cyc(4'h0, 0, 0, 1'b1);
        cyc(4'hE, 8'h12, 8'h34, 1'b1);
        repeat (10) rand_cyc(1'b1);
        do_reset();
        cyc(4'h0, 0, 0, 1'b1);
        cyc(4'h1, 8'h7F, 8'h11, 1'b1);
        cyc(4'h0, 0, 0, 1'b1);

        // Randomized streams, rarely illegal, with waits able to resolve
        for (int seg = 0; seg < 15; seg++) begin
            do_reset();
            repeat (120) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 9) < 3)
                        ir[k] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                end
                r = int'($urandom_range(0, 99));
                cyc((r < 2) ? 4'(13 + $urandom_range(0, 2)) : 4'($urandom_range(0, 12)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 9) != 0));
            end
        end

        @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
